// File: rtl/keypad_scanner.sv
// keypad_scanner: row scan, column decode, frame debounce and auto-repeat.
// Emits a one-cycle key_valid strobe with the accepted keycode.
module keypad_scanner #(
    parameter int SCAN_DIV     = 16,
    parameter int NUM_ROWS     = 4,
    parameter int DEBOUNCE     = 3,
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] column,
    output logic [2:0] sel,
    output logic [3:0] keycode,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi
);

    localparam logic [7:0] DW_MAX  = 8'(SCAN_DIV - 1);
    localparam logic [2:0] ROW_MAX = 3'(NUM_ROWS - 1);
    localparam logic [3:0] DEB     = 4'(DEBOUNCE);
    localparam logic [7:0] RDLY    = 8'(REPEAT_DELAY);
    localparam logic [7:0] RRATE   = 8'(REPEAT_RATE);
    localparam logic [3:0] NONE    = 4'hF;
    localparam logic [3:0] MULTI   = 4'hE;

    logic [2:0] r_col_s1;
    logic [2:0] r_col_s2;
    logic [7:0] r_dwell;
    logic [1:0] r_seen;
    logic [3:0] r_seen_code;
    logic [3:0] r_cand;
    logic [3:0] r_cnt;
    logic [3:0] r_accepted;
    logic [7:0] r_rep;
    logic       r_rate_phase;

    logic       w_sample;
    logic       w_fend;
    logic       w_hit;
    logic       w_multi_hit;
    logic [1:0] w_pos;
    logic [3:0] w_code;
    logic [1:0] w_seen_nxt;
    logic [3:0] w_seen_code_nxt;
    logic [3:0] w_result;
    logic [3:0] w_cnt_nxt;
    logic       w_stable;
    logic [7:0] w_rep_inc;
    logic [7:0] w_rep_target;

    assign w_sample = (r_dwell == DW_MAX);
    assign w_fend   = w_sample && (sel == ROW_MAX);

    // Two-flop synchroniser for the asynchronous column lines
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col_s1 <= 3'b111;
            r_col_s2 <= 3'b111;
        end else begin
            r_col_s1 <= column;
            r_col_s2 <= r_col_s1;
        end
    end

    // Dwell counter and row select sweep
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dwell <= '0;
            sel     <= '0;
        end else if (w_sample) begin
            r_dwell <= '0;
            sel     <= (sel == ROW_MAX) ? 3'd0 : sel + 3'd1;
        end else begin
            r_dwell <= r_dwell + 8'd1;
        end
    end

    // Decode the synchronised columns of the current row
    always_comb begin
        w_hit       = 1'b0;
        w_multi_hit = 1'b0;
        w_pos       = 2'd0;
        w_code      = NONE;
        if (sel <= 3'd3) begin
            case (r_col_s2)
                3'b011:  begin w_hit = 1'b1; w_pos = 2'd0; end
                3'b101:  begin w_hit = 1'b1; w_pos = 2'd1; end
                3'b110:  begin w_hit = 1'b1; w_pos = 2'd2; end
                3'b111:  w_hit = 1'b0;
                default: w_multi_hit = 1'b1;
            endcase
        end
        if (sel == 3'd3) begin
            case (w_pos)
                2'd0:    w_code = 4'hA;
                2'd1:    w_code = 4'h0;
                default: w_code = 4'hB;
            endcase
        end else begin
            w_code = {1'b0, sel} * 4'd3 + {2'b00, w_pos} + 4'd1;
        end
    end

    // Merge this sample into the frame summary and form the frame result
    always_comb begin
        w_seen_nxt      = r_seen;
        w_seen_code_nxt = r_seen_code;
        if (w_multi_hit || (w_hit && r_seen != 2'd0)) begin
            w_seen_nxt = 2'd2;
        end else if (w_hit) begin
            w_seen_nxt      = 2'd1;
            w_seen_code_nxt = w_code;
        end
        case (w_seen_nxt)
            2'd0:    w_result = NONE;
            2'd1:    w_result = w_seen_code_nxt;
            default: w_result = MULTI;
        endcase
        if (w_result == r_cand) begin
            w_cnt_nxt = (r_cnt == DEB) ? r_cnt : r_cnt + 4'd1;
        end else begin
            w_cnt_nxt = 4'd1;
        end
        w_stable     = (w_cnt_nxt == DEB);
        w_rep_inc    = r_rep + 8'd1;
        w_rep_target = r_rate_phase ? RRATE : RDLY;
    end

    // Per-frame key accumulation, cleared at each frame end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seen      <= 2'd0;
            r_seen_code <= NONE;
        end else if (w_fend) begin
            r_seen      <= 2'd0;
            r_seen_code <= NONE;
        end else if (w_sample) begin
            r_seen      <= w_seen_nxt;
            r_seen_code <= w_seen_code_nxt;
        end
    end

    // Debounce, acceptance, auto-repeat and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cand       <= NONE;
            r_cnt        <= '0;
            r_accepted   <= NONE;
            r_rep        <= '0;
            r_rate_phase <= 1'b0;
            keycode      <= NONE;
            key_valid    <= 1'b0;
            key_held     <= 1'b0;
            multi        <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (w_fend) begin
                r_cand <= w_result;
                r_cnt  <= w_cnt_nxt;
                multi  <= (w_result == MULTI);
                if (w_stable && w_result != r_accepted
                    && w_result != MULTI) begin
                    r_accepted   <= w_result;
                    r_rep        <= '0;
                    r_rate_phase <= 1'b0;
                    if (w_result == NONE) begin
                        key_held <= 1'b0;
                    end else begin
                        keycode   <= w_result;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                    end
                end else if (REPEAT_DELAY > 0 && key_held
                             && w_result == r_accepted) begin
                    if (w_rep_inc == w_rep_target) begin
                        key_valid    <= 1'b1;
                        r_rep        <= '0;
                        r_rate_phase <= 1'b1;
                    end else begin
                        r_rep <= w_rep_inc;
                    end
                end else begin
                    r_rep        <= '0;
                    r_rate_phase <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage for the dot-movement logic. Drives the keypad row select `sel` and samples the active-low `column` lines.
- Resolves one key per scan frame, debounces it over whole frames and emits a single-cycle `key_valid` strobe with a 4-bit keycode.
- Optional auto-repeat while a key is held.
- Runs on the divided game clock, so its outputs are consumed directly by the shift/move logic in the same domain.

Parameters:
- SCAN_DIV, 16: clock cycles each row is held on `sel` (dwell); legal range 4..255.
- NUM_ROWS, 4: rows scanned; `sel` counts 0..NUM_ROWS-1; legal range 1..8.
- DEBOUNCE, 3: consecutive identical frames required before a change is accepted; legal range 1..15.
- REPEAT_DELAY, 0: frames from acceptance to the first repeat strobe; 0 disables auto-repeat.
- REPEAT_RATE, 2: frames between subsequent repeat strobes; must be 1 or more.

Ports:
- clk  input  1  game clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- column  input  3  keypad column lines, active-low, asynchronous to clk
- sel  output  3  current scanned row
- keycode  output  4  last accepted key code; stable between strobes
- key_valid  output  1  one-cycle strobe: new press or repeat
- key_held  output  1  level: an accepted key is currently held
- multi  output  1  level: last completed frame saw more than one key

Behaviour:
- Reset values (async, while reset=0): sel=0, dwell counter=0, keycode=4'hF, key_valid=0, key_held=0, multi=0, all debounce/repeat state cleared. Asserting reset mid-operation aborts any frame in progress.
- Synchroniser: `column` passes through a 2-flop synchroniser. All decoding uses the synchronised value.
- Scan:
  - Dwell counter counts 0..SCAN_DIV-1, then `sel` advances and wraps from NUM_ROWS-1 to 0.
  - Columns are sampled only at dwell=SCAN_DIV-1, giving settling time.
  - One frame = SCAN_DIV*NUM_ROWS cycles. The frame ends at the sample of row NUM_ROWS-1.
- Decode per sample (column value -> code):
  - Row r<3: 011 -> 3r+1, 101 -> 3r+2, 110 -> 3r+3.
  - Row 3: 011 -> 4'hA, 101 -> 4'h0, 110 -> 4'hB.
  - Rows above 3: ignored.
  - 111 means no key. Any value with two or more zeros counts as multiple keys.
- Frame result, registered at frame end:
  - NONE (4'hF) if no key was seen.
  - The code, if exactly one key was seen across all rows.
  - MULTI otherwise. `multi` is updated every frame end (1 if MULTI, else 0).
- Debounce:
  - cand holds the previous frame result; cnt is a counter saturating at DEBOUNCE.
  - Frame result equal to cand: cnt++. Otherwise cand <= result and cnt <= 1.
  - When cnt reaches DEBOUNCE and cand differs from the accepted state:
    - cand = key: accepted <= cand, keycode <= cand, key_valid=1 on the next cycle, key_held=1.
    - cand = NONE: key_held=0, keycode unchanged, no strobe.
    - cand = MULTI: accepted state unchanged; key_held stays as it was.
  - A change directly from key A to key B (stable DEBOUNCE frames) produces a new strobe with B.
- Auto-repeat (REPEAT_DELAY>0, key_held=1):
  - Frame counter starts at acceptance.
  - Strobe after REPEAT_DELAY frames, then every REPEAT_RATE frames.
  - The counter clears on release, on a key change, or on reset.
  - Repeat strobes carry the held keycode.
- key_valid timing:
  - Never high for more than one cycle.
  - Never high during reset.
  - At most one strobe per frame.
- Latency: a clean press is strobed 1 cycle after the end of the DEBOUNCE-th full frame in which the key is seen, plus up to one partial frame.

Test Plan:
Bench parameters: SCAN_DIV=4, NUM_ROWS=4, DEBOUNCE=3 (frame = 16 cycles). The bench models the keypad, driving `column` low only while `sel` equals the key's row.

1. Reset release, no keys -> sel goes 0,0,0,0,1,...,3,3,3,3,0. keycode=F, key_valid, key_held and multi stay 0 for 10 frames.
2. Hold key 5 (row 1, column=101) for 6 frames, then release -> exactly one key_valid with keycode=5, after the 3rd full frame. key_held=1 until 3 NONE frames have passed, then 0. No strobe on release; keycode stays 5.
3. Bouncing press (key 2 present on alternate frames for 8 frames) -> no key_valid; key_held stays 0.
4. Keys 1 and 9 held together for 4 frames -> multi=1, no strobe. Then release 9, keeping 1 -> multi=0 at the next frame end; after 3 frames, key_valid with keycode=1.
5. REPEAT_DELAY=4, REPEAT_RATE=2: hold key 0 for 12 full frames -> strobes with keycode=0 at the end of frames 3, 7, 9 and 11 (4 strobes); none after release.
6. Pull reset low for 2 cycles mid-hold of key 7, with key 7 still held -> all outputs return to their reset values immediately. After reset is released, a fresh strobe with keycode=7 follows 3 full frames later.
